control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
Pipelined successor to the combinational main decoder. Decodes the ID-stage opcode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers, presenting per-stage outputs. Adds load-use hazard detection with bubble insertion, branch flush, a parametrised opcode set and a saturating illegal-opcode counter. Sits between the IF/ID register and the five-stage datapath.

Parameters:
REGW, 5, register index width
CNTW, 8, illegal-opcode counter width
EN_ADDI, 1, 1 = decode addi (001000); 0 = addi is illegal
EN_BNE, 1, 1 = decode bne (000101); 0 = bne is illegal

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_opcode  in  6  instruction[31:26]
id_rs  in  REGW  instruction[25:21]
id_rt  in  REGW  instruction[20:16]
flush  in  1  branch taken in MEM; squash ID/EX and EX/MEM
stall  out  1  combinational; 1 = hold PC and IF/ID
id_jump  out  1  combinational; opcode 000010 and id_valid
ex_regdst, ex_alusrc  out  1 each  EX controls
ex_aluop  out  2  00 add, 01 sub, 10 funct
ex_illegal  out  1  instruction in EX was illegal
mem_branch, mem_bne, mem_memread, mem_memwrite  out  1 each  MEM controls
wb_regwrite, wb_memtoreg  out  1 each  WB controls
illegal_cnt  out  CNTW  saturating illegal count

Behaviour:
- Decode, valid opcode with id_valid=1:
  - R-type 000000: regdst, aluop=10, regwrite
  - lw 100011: alusrc, memread, memtoreg, regwrite, aluop=00
  - sw 101011: alusrc, memwrite, aluop=00
  - beq 000100: branch, aluop=01
  - bne 000101: branch, bne, aluop=01
  - addi 001000: alusrc, regwrite, aluop=00
  - j 000010: id_jump only; all bundle bits 0
- Any other opcode, or a disabled one, with id_valid=1 is illegal: bundle all 0, illegal bit 1.
- Bubble means all bundle bits 0, illegal 0, stage valid 0.
- Register pipeline: ID/EX <- decoded bundle plus id_rt; EX/MEM <- ID/EX bundle; MEM/WB <- EX/MEM bundle.
  - A decoded control first appears on ex_* one cycle after being presented in ID.
  - It appears on mem_* two cycles after, and on wb_* three cycles after.
  - Every output is a direct register bit, except stall and id_jump.
- Load-use hazard:
  - Condition: stall = id_valid & ex_memread_q & (ex_rt_q != 0) & ((ex_rt_q == id_rs) | (uses_rt & ex_rt_q == id_rt)) & ~flush.
  - uses_rt is 1 for R-type, sw, beq and bne.
  - On stall: ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
  - The stalled instruction re-decodes next cycle. The hazard then clears because ID/EX holds a bubble, so a stall lasts exactly 1 cycle.
- Flush:
  - ID/EX and EX/MEM load bubbles; MEM/WB advances normally.
  - flush dominates stall, and stall is forced to 0.
- Illegal counter:
  - Increments when an illegal instruction enters ID/EX: id_valid=1, illegal, stall=0, flush=0.
  - Saturates at 2^CNTW-1 and never wraps.
  - ex_illegal is the registered illegal bit.
- id_valid=0: ID/EX loads a bubble, no count, stall=0.
- Reset (asynchronous, any time, including mid-stall or mid-flush): all stage registers, ex_rt_q and illegal_cnt go to 0, so every registered output is 0.
  - First rising edge after deassertion resumes normal operation.
  - No in-flight control survives reset.
- No pending-state machine beyond the pipeline registers; the stall/flush priority is flush > stall > advance.

Test Plan:
- Straight-line flow: lw r2,(r1); add r3,r4,r5; sw; beq presented on consecutive cycles. Check ex/mem/wb bits at exact 1/2/3-cycle offsets, e.g. lw gives mem_memread=1 at cycle+2 and wb_memtoreg=1 at cycle+3.
- Load-use: lw r2 then add r3,r2,r4. stall=1 for exactly one cycle with ex_* all 0 that cycle; add appears in EX the next cycle with ex_aluop=10.
  - lw r0 followed by a consumer of r0: stall stays 0.
  - lw r2 then addi r5,r2 (uses rs): stall.
  - lw r2 then addi with rt=2 and rs≠2: no stall.
- Flush: assert flush with beq in MEM and R-type in EX and ID. The next cycle mem_* and ex_* are 0, wb_* hold the beq bundle (regwrite=0), and stall is 0 even if a hazard is present.
- Illegal opcodes: 111111 on 3 cycles gives ex_illegal pulses and illegal_cnt=3.
  - With CNTW=2, 5 illegal opcodes leave illegal_cnt=3 (saturated).
  - With EN_BNE=0, bne counts as illegal and mem_branch stays 0.
- Reset mid-stall: drop rst_n asynchronously while stall=1 and lw is in MEM. All outputs go 0 immediately; after release, an add produces ex_regdst=1 one cycle later with no stall.

Source files
------------

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - pipelined main decoder with load-use stall, flush and illegal-opcode counter
//
// Decodes the ID-stage opcode into a control bundle and carries it through
// the ID/EX, EX/MEM and MEM/WB registers. Sits between the IF/ID register
// and the five-stage datapath.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   id_valid     IF/ID holds a real instruction
//   id_opcode    instruction[31:26]
//   id_rs        instruction[25:21]
//   id_rt        instruction[20:16]
//   flush        branch taken in MEM; squash ID/EX and EX/MEM
//   stall        combinational; hold PC and IF/ID for one cycle
//   id_jump      combinational; valid j opcode in ID
//   ex_*         EX-stage controls (regdst, alusrc, aluop, illegal)
//   mem_*        MEM-stage controls (branch, bne, memread, memwrite)
//   wb_*         WB-stage controls (regwrite, memtoreg)
//   illegal_cnt  saturating count of illegal instructions entering EX

module control_pipe #(
   parameter int REGW    = 5,
   parameter int CNTW    = 8,
   parameter int EN_ADDI = 1,
   parameter int EN_BNE  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [5:0]      id_opcode,
   input  logic [REGW-1:0] id_rs,
   input  logic [REGW-1:0] id_rt,
   input  logic            flush,
   output logic            stall,
   output logic            id_jump,
   output logic            ex_regdst,
   output logic            ex_alusrc,
   output logic [1:0]      ex_aluop,
   output logic            ex_illegal,
   output logic            mem_branch,
   output logic            mem_bne,
   output logic            mem_memread,
   output logic            mem_memwrite,
   output logic            wb_regwrite,
   output logic            wb_memtoreg,
   output logic [CNTW-1:0] illegal_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   // Full bundle held in ID/EX; later stages keep only the bits they still need.
   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic [1:0] aluop;
      logic       branch;
      logic       bne;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       memtoreg;
      logic       illegal;
   } ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic bne;
      logic memread;
      logic memwrite;
      logic regwrite;
      logic memtoreg;
   } mem_ctrl_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
   } wb_ctrl_t;

   ex_ctrl_t        dec;
   logic            uses_rt;
   logic            jump_dec;
   logic            hazard;
   logic            count_en;

   ex_ctrl_t        ex_q;
   logic [REGW-1:0] ex_rt_q;
   mem_ctrl_t       mem_q;
   wb_ctrl_t        wb_q;

   // ---------------- ID-stage decode ----------------
   always_comb begin
      dec      = '0;
      uses_rt  = 1'b0;
      jump_dec = 1'b0;
      if (id_valid) begin
         case (id_opcode)
            OP_RTYPE: begin
               dec.regdst   = 1'b1;
               dec.aluop    = ALU_FUNCT;
               dec.regwrite = 1'b1;
               uses_rt      = 1'b1;
            end
            OP_LW: begin
               dec.alusrc   = 1'b1;
               dec.memread  = 1'b1;
               dec.memtoreg = 1'b1;
               dec.regwrite = 1'b1;
               dec.aluop    = ALU_ADD;
            end
            OP_SW: begin
               dec.alusrc   = 1'b1;
               dec.memwrite = 1'b1;
               dec.aluop    = ALU_ADD;
               uses_rt      = 1'b1;
            end
            OP_BEQ: begin
               dec.branch = 1'b1;
               dec.aluop  = ALU_SUB;
               uses_rt    = 1'b1;
            end
            OP_BNE: begin
               if (EN_BNE != 0) begin
                  dec.branch = 1'b1;
                  dec.bne    = 1'b1;
                  dec.aluop  = ALU_SUB;
                  uses_rt    = 1'b1;
               end else begin
                  dec.illegal = 1'b1;
               end
            end
            OP_ADDI: begin
               if (EN_ADDI != 0) begin
                  dec.alusrc   = 1'b1;
                  dec.regwrite = 1'b1;
                  dec.aluop    = ALU_ADD;
               end else begin
                  dec.illegal = 1'b1;
               end
            end
            OP_J: begin
               jump_dec = 1'b1;
            end
            default: begin
               dec.illegal = 1'b1;
            end
         endcase
      end
   end

   // Load in EX whose destination feeds the ID instruction; r0 never hazards.
   assign hazard = id_valid & ex_q.memread & (ex_rt_q != '0) &
                   ((ex_rt_q == id_rs) | (uses_rt & (ex_rt_q == id_rt)));

   assign stall    = hazard & ~flush;
   assign id_jump  = jump_dec;
   // dec.illegal already implies id_valid.
   assign count_en = dec.illegal & ~stall & ~flush;

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= '0;
         ex_rt_q     <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         illegal_cnt <= '0;
      end else begin
         // MEM/WB always advances, even under flush.
         wb_q.regwrite <= mem_q.regwrite;
         wb_q.memtoreg <= mem_q.memtoreg;

         if (flush) begin
            ex_q    <= '0;
            ex_rt_q <= '0;
            mem_q   <= '0;
         end else begin
            mem_q.branch   <= ex_q.branch;
            mem_q.bne      <= ex_q.bne;
            mem_q.memread  <= ex_q.memread;
            mem_q.memwrite <= ex_q.memwrite;
            mem_q.regwrite <= ex_q.regwrite;
            mem_q.memtoreg <= ex_q.memtoreg;
            if (stall || !id_valid) begin
               ex_q    <= '0;
               ex_rt_q <= '0;
            end else begin
               ex_q    <= dec;
               ex_rt_q <= id_rt;
            end
         end

         if (count_en && (illegal_cnt != CNT_MAX)) begin
            illegal_cnt <= illegal_cnt + CNT_ONE;
         end
      end
   end

   // ---------------- registered outputs ----------------
   assign ex_regdst    = ex_q.regdst;
   assign ex_alusrc    = ex_q.alusrc;
   assign ex_aluop     = ex_q.aluop;
   assign ex_illegal   = ex_q.illegal;
   assign mem_branch   = mem_q.branch;
   assign mem_bne      = mem_q.bne;
   assign mem_memread  = mem_q.memread;
   assign mem_memwrite = mem_q.memwrite;
   assign wb_regwrite  = wb_q.regwrite;
   assign wb_memtoreg  = wb_q.memtoreg;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - scoreboard bench for control_pipe (default and CNTW=2/no-bne/no-addi builds)

module tb_control_pipe;

   // Bundle encoding used by the bench:
   // [10] regdst [9] alusrc [8:7] aluop [6] branch [5] bne [4] memread
   // [3] memwrite [2] regwrite [1] memtoreg [0] illegal
   localparam logic [10:0] B_R    = 11'b10100000100;
   localparam logic [10:0] B_LW   = 11'b01000010110;
   localparam logic [10:0] B_SW   = 11'b01000001000;
   localparam logic [10:0] B_BEQ  = 11'b00011000000;
   localparam logic [10:0] B_BNE  = 11'b00011100000;
   localparam logic [10:0] B_ADDI = 11'b01000000100;
   localparam logic [10:0] B_ILL  = 11'b00000000001;
   localparam logic [10:0] B_NONE = 11'b00000000000;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [10:0] e;
      logic [10:0] es;
      logic        jump;
   } vec_t;

   typedef struct {
      int          due;
      int          stage;
      logic [10:0] e;
      logic [10:0] es;
      logic [5:0]  op;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [5:0] id_opcode;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       flush;

   logic       stall, id_jump, ex_regdst, ex_alusrc, ex_illegal;
   logic [1:0] ex_aluop;
   logic       mem_branch, mem_bne, mem_memread, mem_memwrite;
   logic       wb_regwrite, wb_memtoreg;
   logic [7:0] illegal_cnt;

   logic       s_stall, s_id_jump, s_ex_regdst, s_ex_alusrc, s_ex_illegal;
   logic [1:0] s_ex_aluop;
   logic       s_mem_branch, s_mem_bne, s_mem_memread, s_mem_memwrite;
   logic       s_wb_regwrite, s_wb_memtoreg;
   logic [1:0] s_illegal_cnt;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   sb_t  sb[$];
   vec_t tbl[9];

   always #5 clk = ~clk;

   control_pipe u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .stall(stall), .id_jump(id_jump),
      .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
      .ex_illegal(ex_illegal), .mem_branch(mem_branch), .mem_bne(mem_bne),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .illegal_cnt(illegal_cnt)
   );

   control_pipe #(.CNTW(2), .EN_ADDI(0), .EN_BNE(0)) u_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .stall(s_stall), .id_jump(s_id_jump),
      .ex_regdst(s_ex_regdst), .ex_alusrc(s_ex_alusrc), .ex_aluop(s_ex_aluop),
      .ex_illegal(s_ex_illegal), .mem_branch(s_mem_branch), .mem_bne(s_mem_bne),
      .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite),
      .wb_regwrite(s_wb_regwrite), .wb_memtoreg(s_wb_memtoreg), .illegal_cnt(s_illegal_cnt)
   );

   function automatic vec_t mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                               logic [10:0] e, logic [10:0] es, logic jump);
      vec_t v;
      v.op = op; v.rs = rs; v.rt = rt; v.e = e; v.es = es; v.jump = jump;
      return v;
   endfunction

   function automatic logic [10:0] obs_m();
      return {ex_regdst, ex_alusrc, ex_aluop, mem_branch, mem_bne, mem_memread,
              mem_memwrite, wb_regwrite, wb_memtoreg, ex_illegal};
   endfunction

   function automatic logic [10:0] obs_s();
      return {s_ex_regdst, s_ex_alusrc, s_ex_aluop, s_mem_branch, s_mem_bne, s_mem_memread,
              s_mem_memwrite, s_wb_regwrite, s_wb_memtoreg, s_ex_illegal};
   endfunction

   function automatic logic [10:0] stage_mask(int s);
      case (s)
         0:       return 11'b11110000001;
         1:       return 11'b00001111000;
         default: return 11'b00000000110;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(int due, int stage, logic [10:0] e, logic [10:0] es, logic [5:0] op);
      sb_t t;
      t.due = due; t.stage = stage; t.e = e; t.es = es; t.op = op;
      sb.push_back(t);
   endtask

   task automatic check_sb();
      logic [10:0] m;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            m = stage_mask(sb[i].stage);
            chk($sformatf("main op%b stage%0d", sb[i].op, sb[i].stage), 32'(obs_m() & m), 32'(sb[i].e & m));
            chk($sformatf("sat op%b stage%0d", sb[i].op, sb[i].stage), 32'(obs_s() & m), 32'(sb[i].es & m));
            sb.delete(i);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      check_sb();
   endtask

   task automatic present(vec_t v, bit exp_stall, bit do_flush, int depth);
      id_valid = 1'b1; id_opcode = v.op; id_rs = v.rs; id_rt = v.rt; flush = do_flush;
      #1;
      chk($sformatf("stall op%b", v.op), 32'(stall), 32'(exp_stall));
      chk($sformatf("sat stall op%b", v.op), 32'(s_stall), 32'(exp_stall));
      chk($sformatf("id_jump op%b", v.op), 32'(id_jump), 32'(v.jump));
      for (int s = 0; s < 3; s++) begin
         if (exp_stall || do_flush) push(cyc + 1 + s, s, B_NONE, B_NONE, v.op);
         else if (s < depth) push(cyc + 1 + s, s, v.e, v.es, v.op);
      end
      if (do_flush) begin
         push(cyc + 1, 1, B_NONE, B_NONE, v.op);
         push(cyc + 2, 2, B_NONE, B_NONE, v.op);
      end
      tick();
      flush = 1'b0;
   endtask

   task automatic idle();
      id_valid = 1'b0; id_opcode = 6'b111111; id_rs = 5'd2; id_rt = 5'd2;
      #1;
      chk("idle stall", 32'(stall), 32'd0);
      for (int s = 0; s < 3; s++) push(cyc + 1 + s, s, B_NONE, B_NONE, 6'b111111);
      tick();
   endtask

   task automatic zero_chk(string n);
      chk({n, " main regs"}, 32'({ex_regdst, ex_alusrc, ex_aluop, ex_illegal, mem_branch, mem_bne,
                                   mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg, illegal_cnt}), 32'd0);
      chk({n, " sat regs"}, 32'({s_ex_regdst, s_ex_alusrc, s_ex_aluop, s_ex_illegal, s_mem_branch, s_mem_bne,
                                  s_mem_memread, s_mem_memwrite, s_wb_regwrite, s_wb_memtoreg, s_illegal_cnt}), 32'd0);
      chk({n, " stall"}, 32'(stall), 32'd0);
   endtask

   initial begin
      tbl[0] = mk(6'b100011, 5'd1,  5'd2,  B_LW,   B_LW,   1'b0);
      tbl[1] = mk(6'b000000, 5'd4,  5'd5,  B_R,    B_R,    1'b0);
      tbl[2] = mk(6'b101011, 5'd6,  5'd7,  B_SW,   B_SW,   1'b0);
      tbl[3] = mk(6'b000100, 5'd8,  5'd9,  B_BEQ,  B_BEQ,  1'b0);
      tbl[4] = mk(6'b000101, 5'd10, 5'd11, B_BNE,  B_ILL,  1'b0);
      tbl[5] = mk(6'b001000, 5'd12, 5'd13, B_ADDI, B_ILL,  1'b0);
      tbl[6] = mk(6'b000010, 5'd0,  5'd0,  B_NONE, B_NONE, 1'b1);
      tbl[7] = mk(6'b111111, 5'd0,  5'd0,  B_ILL,  B_ILL,  1'b0);
      tbl[8] = mk(6'b010101, 5'd3,  5'd3,  B_ILL,  B_ILL,  1'b0);

      rst_n = 1'b0; id_valid = 1'b1; id_opcode = 6'b100011; id_rs = 5'd2; id_rt = 5'd2; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      zero_chk("reset");
      #3 rst_n = 1'b1;
      tick();

      // Illegal opcode three times in a row.
      for (int k = 0; k < 3; k++) present(tbl[7], 1'b0, 1'b0, 3);
      idle();
      chk("illegal_cnt after 3", 32'(illegal_cnt), 32'd3);
      chk("sat illegal_cnt after 3", 32'(s_illegal_cnt), 32'd3);

      // Straight-line flow through the whole opcode table.
      for (int k = 0; k < 9; k++) present(tbl[k], 1'b0, 1'b0, 3);
      repeat (3) idle();
      chk("illegal_cnt after table", 32'(illegal_cnt), 32'd5);
      chk("sat illegal_cnt saturated", 32'(s_illegal_cnt), 32'd3);

      // Load-use: lw r2 then add r3,r2,r4.
      present(tbl[0], 1'b0, 1'b0, 3);
      present(mk(6'b000000, 5'd2, 5'd4, B_R, B_R, 1'b0), 1'b1, 1'b0, 3);
      present(mk(6'b000000, 5'd2, 5'd4, B_R, B_R, 1'b0), 1'b0, 1'b0, 3);
      idle();
      // lw r0 then consumer of r0.
      present(mk(6'b100011, 5'd1, 5'd0, B_LW, B_LW, 1'b0), 1'b0, 1'b0, 3);
      present(mk(6'b000000, 5'd0, 5'd0, B_R, B_R, 1'b0), 1'b0, 1'b0, 3);
      idle();
      // lw r2 then addi r5,r2.
      present(tbl[0], 1'b0, 1'b0, 3);
      present(mk(6'b001000, 5'd2, 5'd5, B_ADDI, B_ILL, 1'b0), 1'b1, 1'b0, 3);
      present(mk(6'b001000, 5'd2, 5'd5, B_ADDI, B_ILL, 1'b0), 1'b0, 1'b0, 3);
      idle();
      // lw r2 then addi with rt=2, rs=7.
      present(tbl[0], 1'b0, 1'b0, 3);
      present(mk(6'b001000, 5'd7, 5'd2, B_ADDI, B_ILL, 1'b0), 1'b0, 1'b0, 3);
      idle();
      // lw r2 then sw with rt=2 (rt consumer).
      present(tbl[0], 1'b0, 1'b0, 3);
      present(mk(6'b101011, 5'd7, 5'd2, B_SW, B_SW, 1'b0), 1'b1, 1'b0, 3);
      present(mk(6'b101011, 5'd7, 5'd2, B_SW, B_SW, 1'b0), 1'b0, 1'b0, 3);
      repeat (3) idle();

      // Flush with beq in MEM, lw r2 in EX and a dependent add in ID.
      present(tbl[3], 1'b0, 1'b0, 3);
      present(tbl[0], 1'b0, 1'b0, 1);
      present(mk(6'b000000, 5'd2, 5'd4, B_R, B_R, 1'b0), 1'b0, 1'b1, 3);
      present(mk(6'b000000, 5'd2, 5'd4, B_R, B_R, 1'b0), 1'b0, 1'b0, 3);
      repeat (3) idle();

      // Reset while stalled with lw in MEM.
      present(tbl[0], 1'b0, 1'b0, 1);
      present(mk(6'b100011, 5'd7, 5'd3, B_LW, B_LW, 1'b0), 1'b0, 1'b0, 1);
      id_valid = 1'b1; id_opcode = 6'b000000; id_rs = 5'd3; id_rt = 5'd4;
      #1;
      chk("pre-reset stall", 32'(stall), 32'd1);
      chk("pre-reset mem_memread", 32'(mem_memread), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      zero_chk("async reset");
      sb.delete();
      tick();
      tick();
      zero_chk("held reset");
      #3 rst_n = 1'b1;
      tick();
      present(mk(6'b000000, 5'd3, 5'd4, B_R, B_R, 1'b0), 1'b0, 1'b0, 3);
      idle();
      id_valid = 1'b0;
      repeat (4) tick();
      chk("illegal_cnt after reset", 32'(illegal_cnt), 32'd0);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
